// File: rtl/alu_pkg.sv
// Shared constants for the ALU add/sub datapath.
//   WORD_W  : datapath width
//   GRP_W   : carry-lookahead group width
//   SAT_POS : most positive signed word, used when a sum overflows upward
//   SAT_NEG : most negative signed word, used when a sum overflows downward
package alu_pkg;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned GRP_W  = 4;
    localparam logic [WORD_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WORD_W-1:0] SAT_NEG = 16'h8000;
endpackage : alu_pkg

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead group.
// Ports:
//   a, b (in, 4)  : group operand bits
//   cin  (in, 1)  : carry into bit 0 of the group
//   s    (out, 4) : group sum bits
//   P    (out, 1) : group propagate (carry passes through the whole group)
//   G    (out, 1) : group generate (group creates a carry on its own)
// Internal carries are formed directly from g/p terms, so no bit waits on
// the carry of its neighbour.
module cla_4bit
    import alu_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] s,
    output logic             P,
    output logic             G
);
    logic [GRP_W-1:0] g_s;
    logic [GRP_W-1:0] p_s;
    logic [GRP_W-1:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Flat lookahead carries into each bit position of the group.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);

    assign s = p_s ^ c_s;
    assign P = &p_s;
    assign G = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
endmodule : cla_4bit

// File: rtl/cla_addsub_16bit.sv
// 16-bit signed saturating adder/subtractor with registered N/Z/V flags.
// Ports:
//   clk     (in, 1)   : system clock
//   rst_n   (in, 1)   : asynchronous active-low reset, clears the flags
//   a, b    (in, 16)  : signed operands
//   sub     (in, 1)   : 0 = a+b, 1 = a-b
//   flag_en (in, 1)   : capture N/Z/V on the next rising clk edge
//   sum     (out, 16) : saturated result, combinational
//   cout    (out, 1)  : raw carry out of bit 15, combinational (1 = no borrow on sub)
//   N, Z, V (out, 1)  : registered negative / zero / signed-overflow flags
module cla_addsub_16bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              sub,
    input  logic              flag_en,
    output logic [WORD_W-1:0] sum,
    output logic              cout,
    output logic              N,
    output logic              Z,
    output logic              V
);
    localparam int unsigned NGRP = WORD_W / GRP_W;

    logic [WORD_W-1:0] bb_s;
    logic [WORD_W-1:0] raw_s;
    logic [NGRP-1:0]   gp_s;
    logic [NGRP-1:0]   gg_s;
    logic [NGRP:0]     gc_s;
    logic              ovf_s;
    logic [WORD_W-1:0] sum_s;
    logic              n_r;
    logic              z_r;
    logic              v_r;

    // Subtraction is a + ~b + 1; the +1 enters as the carry-in.
    assign bb_s = b ^ {WORD_W{sub}};

    // Second-level lookahead: every group carry comes straight from P/G.
    assign gc_s[0] = sub;
    assign gc_s[1] = gg_s[0] | (gp_s[0] & sub);
    assign gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & sub);
    assign gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                   | (gp_s[2] & gp_s[1] & gp_s[0] & sub);
    assign gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                   | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                   | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & sub);

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        cla_4bit u_grp (
            .a   (a[gi*GRP_W +: GRP_W]),
            .b   (bb_s[gi*GRP_W +: GRP_W]),
            .cin (gc_s[gi]),
            .s   (raw_s[gi*GRP_W +: GRP_W]),
            .P   (gp_s[gi]),
            .G   (gg_s[gi])
        );
    end

    // Same-sign operands giving a result of the other sign means overflow.
    assign ovf_s = (a[WORD_W-1] == bb_s[WORD_W-1]) && (raw_s[WORD_W-1] != a[WORD_W-1]);

    // Saturation mux: clamp toward the sign of operand A on overflow.
    always_comb begin
        sum_s = raw_s;
        if (ovf_s && !a[WORD_W-1]) begin
            sum_s = SAT_POS;
        end else if (ovf_s && a[WORD_W-1]) begin
            sum_s = SAT_NEG;
        end else begin
            sum_s = raw_s;
        end
    end

    // Flag register: capture from the saturated result when enabled, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r <= 1'b0;
            z_r <= 1'b0;
            v_r <= 1'b0;
        end else if (flag_en) begin
            n_r <= sum_s[WORD_W-1];
            z_r <= (sum_s == {WORD_W{1'b0}});
            v_r <= ovf_s;
        end else begin
            n_r <= n_r;
            z_r <= z_r;
            v_r <= v_r;
        end
    end

    assign sum  = sum_s;
    assign cout = gc_s[NGRP];
    assign N    = n_r;
    assign Z    = z_r;
    assign V    = v_r;
endmodule : cla_addsub_16bit

// File: tb/tb_cla_addsub_16bit.sv
// Bench for cla_addsub_16bit: directed vector table, hand sequences for
// flag hold and asynchronous reset, then randomized operations compared
// against an integer-arithmetic reference model.
module tb_cla_addsub_16bit;
    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        flag_en;
    logic [15:0] sum;
    logic        cout;
    logic        N;
    logic        Z;
    logic        V;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_n;
        logic        e_z;
        logic        e_v;
    } vec_t;

    vec_t vecs[12];

    cla_addsub_16bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .sub     (sub),
        .flag_en (flag_en),
        .sum     (sum),
        .cout    (cout),
        .N       (N),
        .Z       (Z),
        .V       (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer result, clamped to the signed 16-bit range.
    function automatic void ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                      input logic rsub, output logic [15:0] rs,
                                      output logic rc, output logic rv);
        int sa;
        int sb;
        int r;
        int ua;
        int ub;
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        ua = int'(ra);
        ub = int'(rb);
        r  = rsub ? (sa - sb) : (sa + sb);
        rv = (r > 32767) || (r < -32768);
        if (r > 32767)       rs = 16'h7FFF;
        else if (r < -32768) rs = 16'h8000;
        else                 rs = r[15:0];
        rc = rsub ? (ua >= ub) : ((ua + ub) > 65535);
    endfunction

    logic [15:0] m_sum;
    logic        m_cout;
    logic        m_v;
    logic        m_n;
    logic        m_z;
    logic        m_fv;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        a       = 16'h0000;
        b       = 16'h0000;
        sub     = 1'b0;
        flag_en = 1'b0;

        //            a         b         sub   sum       cout  N     Z     V
        vecs[0]  = '{16'd20000, 16'd10000, 1'b0, 16'd30000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'd20000, 16'd10000, 1'b1, 16'd10000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'd20000, 16'd20000, 1'b0, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'hB1E0,  16'd20000, 1'b1, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'd5,     16'd5,     1'b1, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000,  16'h8000,  1'b1, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000,  16'h8000,  1'b1, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h7FFF,  16'h0001,  1'b0, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000,  16'h8000,  1'b0, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'hFFFF,  16'hFFFF,  1'b0, 16'hFFFE,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'h8000,  16'h0001,  1'b1, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state.
        #12;
        chk("reset_N", {15'd0, N}, 16'd0);
        chk("reset_Z", {15'd0, Z}, 16'd0);
        chk("reset_V", {15'd0, V}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; flag_en = 1'b1;
            #1;
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].e_sum);
            chk($sformatf("vec%0d_cout", i), {15'd0, cout}, {15'd0, vecs[i].e_cout});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_N", i), {15'd0, N}, {15'd0, vecs[i].e_n});
            chk($sformatf("vec%0d_Z", i), {15'd0, Z}, {15'd0, vecs[i].e_z});
            chk($sformatf("vec%0d_V", i), {15'd0, V}, {15'd0, vecs[i].e_v});
        end

        // Flag hold: capture Z=1 from 5-5, then change operands with flag_en=0.
        @(negedge clk);
        a = 16'd5; b = 16'd5; sub = 1'b1; flag_en = 1'b1;
        @(posedge clk); #1;
        chk("hold_setZ", {15'd0, Z}, 16'd1);
        @(negedge clk);
        a = 16'd1; flag_en = 1'b0;
        @(posedge clk); #1;
        chk("hold_Z", {15'd0, Z}, 16'd1);
        chk("hold_sum", sum, 16'hFFFC);
        @(posedge clk); #1;
        chk("hold_Z2", {15'd0, Z}, 16'd1);

        // Async reset between edges clears flags; sum keeps tracking.
        @(negedge clk);
        a = 16'h8000; b = 16'h0001; sub = 1'b1; flag_en = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_N", {15'd0, N}, 16'd1);
        chk("pre_rst_V", {15'd0, V}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_N", {15'd0, N}, 16'd0);
        chk("rst_Z", {15'd0, Z}, 16'd0);
        chk("rst_V", {15'd0, V}, 16'd0);
        chk("rst_sum", sum, 16'h8000);
        a = 16'd3; b = 16'd3;
        #1;
        chk("rst_sum_track", sum, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_Z", {15'd0, Z}, 16'd1);
        chk("post_rst_V", {15'd0, V}, 16'd0);

        // Randomized operations against the reference model.
        m_n = N; m_z = Z; m_fv = V;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       a = 16'h7FFF ^ 16'($urandom_range(0, 3));
                1:       a = 16'h8000 ^ 16'($urandom_range(0, 3));
                default: a = 16'($urandom);
            endcase
            b       = 16'($urandom);
            sub     = 1'($urandom);
            flag_en = 1'($urandom);
            ref_model(a, b, sub, m_sum, m_cout, m_v);
            #1;
            chk($sformatf("rnd%0d_sum", i), sum, m_sum);
            chk($sformatf("rnd%0d_cout", i), {15'd0, cout}, {15'd0, m_cout});
            if (flag_en) begin
                m_n  = m_sum[15];
                m_z  = (m_sum == 16'h0000);
                m_fv = m_v;
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_flags", i), {13'd0, N, Z, V}, {13'd0, m_n, m_z, m_fv});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_cla_addsub_16bit
